mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Consumes the register-file read ports (rs → operand_a, rt → operand_b) for mult, multu, div and divu.
- Returns HI/LO to the write-back mux for mfhi/mflo.
- Accepts mthi/mtlo writes from the write-data path.
- Radix-2: one multiply or divide step per clock; the controller stalls the pipeline while busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
start  input  1  launch operation; sampled only in IDLE.
op  input  2  00 mult, 01 multu, 10 div, 11 divu.
operand_a  input  WIDTH  rs value (multiplicand / dividend).
operand_b  input  WIDTH  rt value (multiplier / divisor).
signal_hi_write  input  1  mthi strobe.
signal_lo_write  input  1  mtlo strobe.
write_data  input  WIDTH  mthi/mtlo data.
busy  output  1  operation in flight.
done  output  1  one-cycle pulse; HI/LO hold the new result.
div_by_zero  output  1  pulses with done when a div/divu had operand_b == 0.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Clock is clk, reset is rst: one clock, reset synchronous and active-high.
- Reset values: state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0.
- Reset mid-operation aborts the operation. HI/LO are cleared and no done is produced.
- State sequence: IDLE → PREP → RUN → FIX → IDLE.
- IDLE:
  - If start=1 at edge E0: latch op and operands, set busy=1, go to PREP.
  - Otherwise, apply signal_hi_write/signal_lo_write (both may fire together).
  - If start and an mthi/mtlo strobe arrive together in IDLE, start wins and the write is dropped.
- PREP (1 cycle):
  - Signed ops: take magnitudes of the operands and record the result signs.
  - Clear the accumulator/remainder. Iteration counter = 0.
- RUN (WIDTH cycles, edges E2..E(WIDTH+1)):
  - Multiply: shift-add on a 2*WIDTH product.
  - Divide: restoring shift-subtract. Quotient bit is 1 when the trial remainder is ≥ 0.
  - The counter increments each cycle. Leave RUN after count WIDTH-1.
- FIX (1 cycle, edge E(WIDTH+2)=E34 at default):
  - Apply sign correction and write HI/LO. Drive done=1 and busy=0 for the following cycle.
  - div_by_zero=1 in the same cycle if applicable. Return to IDLE.
- Latency: start sampled at E0 → results valid and done high after E34 (WIDTH+2 edges).
- Result rules:
  - mult/multu: {hi,lo} = full 2*WIDTH product (signed or unsigned).
  - div/divu: lo = quotient, hi = remainder. The signed quotient truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero: lo = all ones, hi = operand_a. Full latency still applies and div_by_zero pulses.
  - Signed overflow, most-negative value / -1: lo = 0x80000000, hi = 0, with no flag.
- While busy:
  - start is ignored, with no queuing.
  - mthi/mtlo strobes are ignored.
  - hi/lo keep their old values until FIX.
- start in the same cycle that done is high is accepted, because the state is already IDLE.
- Operands are captured at E0, so later changes on operand_a/b have no effect.

Decomposition:
- Shared package/include (mips_defs): op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and the state encoding localparams.
- One sub-module: mips_muldiv_datapath, holding the shift registers, adder/subtractor, negation logic and iteration counter.
- The top level holds the FSM, HI/LO registers and the mthi/mtlo write logic.

Test Plan:
- mult: a=0xFFFFFFFD (-3), b=7 → after 34 edges hi=0xFFFFFFFF, lo=0xFFFFFFEB, done one cycle, busy low.
- multu: a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then div a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu: a=100, b=7 → lo=14, hi=2. div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
- div by zero: divu a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678, div_by_zero pulse coincident with done.
- mthi 0xAAAA5555 in IDLE → hi updated next edge. Start a mult, then pulse start and mtlo mid-RUN → both ignored, and only the first result appears.
- Reset at RUN cycle 10 → next cycle busy=0, hi=lo=0, no done. A following start completes normally in 34 edges.

Source files
------------

// File: rtl/mips_defs.sv
// Shared encodings for the MIPS multiply/divide unit: operation codes and
// controller state encoding.
package mips_defs;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_PREP = ST_PREP,
    S_RUN  = ST_RUN,
    S_FIX  = ST_FIX
  } md_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mips_muldiv_datapath.sv
// Radix-2 multiply/divide datapath: operand capture, magnitude/sign prep,
// shift-add / restoring shift-subtract iteration and sign-corrected results.
module mips_muldiv_datapath
  import mips_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             latch_i,
  input  logic             prep_i,
  input  logic             step_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, mag_b_q, mq_q, acc_q;
  logic [WIDTH-1:0] mq_d, acc_d;
  logic             neg_q, neg_rem_q;
  logic [CW-1:0]    cnt_q;

  logic             is_signed, is_div, a_neg, b_neg, ge;
  logic [WIDTH-1:0] a_mag, b_mag, trial, quo, rem;
  logic [WIDTH:0]   add_sum, shifted;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign is_signed = op_is_signed(op_q);
  assign is_div    = op_is_div(op_q);
  assign a_neg     = is_signed & a_q[WIDTH-1];
  assign b_neg     = is_signed & b_q[WIDTH-1];
  assign a_mag     = a_neg ? -a_q : a_q;
  assign b_mag     = b_neg ? -b_q : b_q;

  // Multiply keeps the multiplier in mq_q and shifts product bits in from the top;
  // divide shifts dividend bits out of mq_q into the remainder and quotient bits back in.
  assign add_sum = {1'b0, acc_q} + {1'b0, (mq_q[0] ? mag_b_q : '0)};
  assign shifted = {acc_q, mq_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, mag_b_q};
  assign trial   = shifted[WIDTH-1:0] - mag_b_q;

  always_comb begin
    acc_d = acc_q;
    mq_d  = mq_q;
    if (is_div) begin
      acc_d = ge ? trial : shifted[WIDTH-1:0];
      mq_d  = {mq_q[WIDTH-2:0], ge};
    end else begin
      acc_d = add_sum[WIDTH:1];
      mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= MD_MULT;
      a_q       <= '0;
      b_q       <= '0;
      mag_b_q   <= '0;
      mq_q      <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else if (latch_i) begin
      op_q <= op_i;
      a_q  <= a_i;
      b_q  <= b_i;
    end else if (prep_i) begin
      mq_q      <= a_mag;
      mag_b_q   <= b_mag;
      acc_q     <= '0;
      neg_q     <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      cnt_q     <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last_o = (cnt_q == CW'(WIDTH - 1));

  // Most-negative / -1 needs no special case: the magnitude quotient 2^(W-1) negates to itself.
  assign prod   = {acc_q, mq_q};
  assign prod_s = neg_q ? -prod : prod;
  assign quo    = neg_q ? -mq_q : mq_q;
  assign rem    = neg_rem_q ? -acc_q : acc_q;
  assign dbz_o  = is_div && (b_q == '0);

  always_comb begin
    res_hi_o = prod_s[2*WIDTH-1:WIDTH];
    res_lo_o = prod_s[WIDTH-1:0];
    if (dbz_o) begin
      res_hi_o = a_q;
      res_lo_o = '1;
    end else if (is_div) begin
      res_hi_o = rem;
      res_lo_o = quo;
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: sequencing FSM, architectural HI/LO
// registers and mthi/mtlo write handling around the iterative datapath.
//
//   state | meaning
//   IDLE  | accept start or mthi/mtlo writes
//   PREP  | take operand magnitudes, record result signs, clear accumulator
//   RUN   | WIDTH radix-2 iterations
//   FIX   | sign-correct, write HI/LO, pulse done
module mips_muldiv_unit
  import mips_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             signal_hi_write,
  input  logic             signal_lo_write,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        state_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             last, dbz;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             latch;

  assign latch = (state_q == S_IDLE) && start;

  mips_muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .latch_i  (latch),
    .prep_i   (state_q == S_PREP),
    .step_i   (state_q == S_RUN),
    .op_i     (op),
    .a_i      (operand_a),
    .b_i      (operand_b),
    .last_o   (last),
    .dbz_o    (dbz),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end else begin
            if (signal_hi_write) hi_q <= write_data;
            if (signal_lo_write) lo_q <= write_data;
          end
        end
        S_PREP: state_q <= S_RUN;
        S_RUN:  if (last) state_q <= S_FIX;
        S_FIX: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
          dbz_q   <= dbz;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed and randomized checks of mips_muldiv_unit against a plain-arithmetic
// reference of the MIPS mult/multu/div/divu HI/LO results.
module tb_mips_muldiv_unit;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic        clk = 1'b0;
  logic        rst, start, hw, lw;
  logic [1:0]  op;
  logic [31:0] a, b, wd;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .op              (op),
    .operand_a       (a),
    .operand_b       (b),
    .signal_hi_write (hw),
    .signal_lo_write (lw),
    .write_data      (wd),
    .busy            (busy),
    .done            (done),
    .div_by_zero     (dbz),
    .hi              (hi),
    .lo              (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rh, output logic [31:0] rl, output logic rz);
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 sx, sy;
    rz = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      OP_MULT: begin
        sp = $signed(x) * $signed(y);
        {rh, rl} = sp;
      end
      OP_MULTU: begin
        up = {32'b0, x} * {32'b0, y};
        {rh, rl} = up;
      end
      default: begin
        if (y == 32'd0) begin
          rz = 1'b1;
          rh = x;
          rl = 32'hFFFF_FFFF;
        end else if (o == OP_DIVU) begin
          rl = x / y;
          rh = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000;
          rh = 32'h0;
        end else begin
          sx = $signed(x);
          sy = $signed(y);
          rl = sx / sy;
          rh = sx % sy;
        end
      end
    endcase
  endfunction

  // Operands are scrambled right after E0 so any late capture shows up as a wrong result.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
  endtask

  task automatic finish_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input int already);
    logic [31:0] rh, rl;
    logic        rz;
    int          n;
    model(o, x, y, rh, rl, rz);
    n = already;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 20) chk({tag, " hold"}, {31'b0, busy, hi, lo}, {31'b0, 1'b1, exp_hi, exp_lo});
    end while (!done && n < 40);
    chk({tag, " latency"}, 64'(n), 64'd34);
    chk({tag, " result"}, {hi, lo}, {rh, rl});
    chk({tag, " flags"}, {61'b0, busy, done, dbz}, {61'b0, 1'b0, 1'b1, rz});
    exp_hi = rh;
    exp_lo = rl;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic        seen_done;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; hw = 1'b0; lw = 1'b0; op = '0; a = '0; b = '0; wd = '0;
    @(posedge clk); #1;
    chk("reset state", {29'b0, busy, done, dbz, hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    finish_op("mult -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 0);
    @(posedge clk); #1;
    chk("done pulse width", {62'b0, busy, done}, 64'd0);

    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);   // accepted while done is high
    chk("back-to-back busy", {63'b0, busy}, 64'd1);
    finish_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);

    launch(OP_DIVU, 32'd100, 32'd7);
    finish_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 0);
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    launch(OP_DIVU, 32'h1234_5678, 32'd0);
    finish_op("divu by zero", OP_DIVU, 32'h1234_5678, 32'd0, 0);
    @(posedge clk); #1;
    chk("dbz pulse width", {62'b0, done, dbz}, 64'd0);

    hw = 1'b1; wd = 32'hAAAA_5555;
    @(posedge clk); #1;
    hw = 1'b0;
    exp_hi = 32'hAAAA_5555;
    chk("mthi", {hi, lo}, {exp_hi, exp_lo});
    hw = 1'b1; lw = 1'b1; wd = 32'h1357_9BDF;
    @(posedge clk); #1;
    hw = 1'b0; lw = 1'b0;
    exp_hi = 32'h1357_9BDF; exp_lo = 32'h1357_9BDF;
    chk("mthi+mtlo", {hi, lo}, {exp_hi, exp_lo});

    hw = 1'b1; lw = 1'b1; wd = 32'hDEAD_BEEF;
    launch(OP_MULTU, 32'd6, 32'd9);
    hw = 1'b0; lw = 1'b0;
    chk("start beats strobe", {hi, lo}, {exp_hi, exp_lo});
    finish_op("multu 6*9", OP_MULTU, 32'd6, 32'd9, 0);

    launch(OP_MULT, 32'h0001_2345, 32'hFFFF_0003);
    repeat (11) @(posedge clk);
    #1;
    start = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5; lw = 1'b1; wd = 32'h0BAD_F00D;
    @(posedge clk); #1;
    start = 1'b0; lw = 1'b0;
    finish_op("mult ignores mid-run", OP_MULT, 32'h0001_2345, 32'hFFFF_0003, 12);
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen_done |= done | busy;
    end
    chk("no queued start", {31'b0, seen_done, lo}, {32'b0, exp_lo});

    launch(OP_DIV, 32'h7FFF_0000, 32'd3);
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    chk("reset abort", {29'b0, busy, done, dbz, hi, lo}, 64'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen_done |= done | busy;
    end
    chk("no done after abort", {63'b0, seen_done}, 64'd0);
    launch(OP_DIV, 32'h7FFF_0000, 32'd3);
    finish_op("div after reset", OP_DIV, 32'h7FFF_0000, 32'd3, 0);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      launch(ro, ra, rb);
      finish_op("random", ro, ra, rb, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
